// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte bus of one UART lane.
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   parity_err one-cycle pulse on parity mismatch (0 when parity is disabled)
//   busy       receiver is inside a frame (any state other than idle)
// The master modport belongs to the receiver; the slave modport belongs to the
// downstream byte logic.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, LSB first, with mid-bit sampling,
// start-bit glitch rejection and stop-bit framing check.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit (frame becomes 11 bits).
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   rx     asynchronous serial line, idle high
//   bus    uart_rx_if.master: rx_data, rx_valid, frame_err, parity_err, busy
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   CNT_W         width of the bit-timing counter (holds CLKS_PER_BIT-1)
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  uart_rx_if.master   bus
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             ferr_r;
  logic             busy_r;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_r;
  logic             perr_r;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  assign rx_s = rx_sync_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM: bit timing, sampling, framing checks and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r  <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (!rx_s) begin
            state_r <= S_START;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        S_START: begin
          // Re-check the line half a bit in; a high level means a glitch.
          if (cnt_r == HALF_LAST) begin
            cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= S_DATA;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r              <= '0;
            shift_r[bit_idx_r] <= rx_s;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= S_PARITY;
`else
              state_r <= S_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= '0;
            par_bit_r <= rx_s;
            state_r   <= S_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          // A low stop bit outranks a parity mismatch: only frame_err fires.
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (parity_mismatch(shift_r, par_bit_r)) begin
                perr_r <= 1'b1;
              end else begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end
`else
              data_r  <= shift_r;
              valid_r <= 1'b1;
`endif
            end else begin
              ferr_r  <= 1'b1;
              state_r <= S_BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // Hold here while the line stays low so a break reports only once.
          if (rx_s) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_r;
  assign bus.rx_valid  = valid_r;
  assign bus.frame_err = ferr_r;
  assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Serial frames are built bit by bit from the byte to send; a negedge monitor
// collects every strobe, and expectations come from the framing rules
// (good stop bit -> byte delivered, low stop bit -> one frame error).
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk;
  logic reset;
  logic rx;
  int   cyc;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  int vectors;
  int miscompares;

  // Monitor results
  logic [7:0] valid_q[$];
  int         valid_cyc_q[$];
  int         ferr_cnt;
  int         perr_cnt;
  int         both_cnt;

  // Frame bookkeeping
  int         start_cyc;
  logic       busy_mid;
  logic [7:0] exp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      valid_q.push_back(bus.rx_data);
      valid_cyc_q.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.parity_err === 1'b1) perr_cnt++;
    if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_data(input int i);
    return (valid_q.size() > i) ? {24'h0, valid_q[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int q_cyc(input int i);
    return (valid_cyc_q.size() > i) ? valid_cyc_q[i] : -100000;
  endfunction

  // Leaves the bench aligned to a negedge with empty monitor records.
  task automatic clear_mon();
    @(posedge clk);
    valid_q.delete();
    valid_cyc_q.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Full frame starting at the current negedge; busy sampled mid data bit 4.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        rx = d[i];
        repeat (CPB / 2) @(negedge clk);
        busy_mid = bus.busy;
        repeat (CPB - CPB / 2) @(negedge clk);
      end else begin
        send_bit(d[i]);
      end
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) rx = 1'b1;
`endif
    send_bit(stop_bit);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'h0, bus.rx_data}, 32'h00);
    check({tag, "_valid"}, {31'h0, bus.rx_valid}, 32'h0);
    check({tag, "_ferr"},  {31'h0, bus.frame_err}, 32'h0);
    check({tag, "_perr"},  {31'h0, bus.parity_err}, 32'h0);
    check({tag, "_busy"},  {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    int lat;
    logic [7:0] d;
    logic stop;
    logic bad;
    int gap;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    ferr_cnt = 0;
    perr_cnt = 0;
    both_cnt = 0;
    busy_mid = 1'b0;
    exp_data = 8'h00;
    reset = 1'b1;
    rx = 1'b1;

    // Reset state
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xA5: one strobe, busy during the frame, latency ~154 cycles
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    exp_data = 8'hA5;
    check("a5_count", valid_q.size(), 1);
    check("a5_data", q_data(0), {24'h0, exp_data});
    check("a5_out", {24'h0, bus.rx_data}, {24'h0, exp_data});
    check("a5_busy_mid", {31'h0, busy_mid}, 1);
    check("a5_busy_after", {31'h0, bus.busy}, 0);
    check("a5_ferr", ferr_cnt, 0);
    lat = q_cyc(0) - start_cyc - 1;
    check("a5_latency", {31'h0, (lat >= 2 + CPB / 2 + 9 * CPB - 1) && (lat <= 2 + CPB / 2 + 9 * CPB + 1)}, 1);

    // Start glitch: 4 low cycles, no strobe, then 0x3C
    clear_mon();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_valid", valid_q.size(), 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_busy", {31'h0, bus.busy}, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    exp_data = 8'h3C;
    check("3c_count", valid_q.size(), 1);
    check("3c_data", q_data(0), {24'h0, exp_data});

    // 0x55 with low stop bit and a held-low line
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("brk_busy_low", {31'h0, bus.busy}, 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_valid", valid_q.size(), 0);
    check("brk_data_kept", {24'h0, bus.rx_data}, {24'h0, exp_data});
    check("brk_busy_after", {31'h0, bus.busy}, 0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    exp_data = 8'hFF;
    check("b2b_count", valid_q.size(), 2);
    check("b2b_first", q_data(0), 32'h00);
    check("b2b_second", q_data(1), 32'hFF);
    check("b2b_spacing", q_cyc(1) - q_cyc(0), 10 * CPB);

    // Randomized frames against the framing rules
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      gap = $urandom_range(0, 8);
      clear_mon();
      send_frame(d, stop, bad);
      rx = 1'b1;
      repeat (4 + gap) @(negedge clk);
      if (stop && !bad) exp_data = d;
      check("rnd_valid", valid_q.size(), (stop && !bad) ? 1 : 0);
      check("rnd_ferr", ferr_cnt, stop ? 0 : 1);
      check("rnd_perr", perr_cnt, (stop && bad) ? 1 : 0);
      check("rnd_data", {24'h0, bus.rx_data}, {24'h0, exp_data});
      check("rnd_busy", {31'h0, bus.busy}, 0);
    end

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    exp_data = 8'h07;
    check("par_ok_valid", valid_q.size(), 1);
    check("par_ok_data", q_data(0), 32'h07);
    check("par_ok_perr", perr_cnt, 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_bad_valid", valid_q.size(), 0);
    check("par_bad_perr", perr_cnt, 1);
`endif

    // Reset during bit 4 of 0x81, then 0x7E
    clear_mon();
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    exp_data = 8'h00;
    check("midrst_no_strobe", valid_q.size() + ferr_cnt + perr_cnt, 0);
    check("midrst_data", {24'h0, bus.rx_data}, {24'h0, exp_data});
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("7e_count", valid_q.size(), 1);
    check("7e_data", q_data(0), 32'h7E);

    check("strobe_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
